// File: rtl/booth_pp_accum_if.sv
// rtl/booth_pp_accum_if.sv - partial-product input and product output handshake bundle
interface booth_pp_accum_if #(
    parameter int n = 8
);
    logic                       pp_valid;
    logic                       pp_ready;
    logic [n+1:0]               pp_in;
    logic                       prod_valid;
    logic                       prod_ready;
    logic [2*n-1:0]             prod;
    logic [$clog2(n/2):0]       pp_cnt;

    modport master (
        output pp_valid,
        output pp_in,
        output prod_ready,
        input  pp_ready,
        input  prod_valid,
        input  prod,
        input  pp_cnt
    );

    modport slave (
        input  pp_valid,
        input  pp_in,
        input  prod_ready,
        output pp_ready,
        output prod_valid,
        output prod,
        output pp_cnt
    );
endinterface

// File: rtl/booth_pp_accum.sv
// rtl/booth_pp_accum.sv - accumulates n/2 radix-4 Booth partial products into a 2n-bit product
module booth_pp_accum #(
    parameter int n = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    booth_pp_accum_if.slave     bus
);
    localparam int CW = $clog2(n/2) + 1;
    localparam logic [CW-1:0] LAST_K = CW'(n/2 - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2*n-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*n-1:0]  pp_ext;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear outranks both a PP transfer and a product handoff
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pp_ext  = {{(n-2){bus.pp_in[n+1]}}, bus.pp_in};
        xfer    = bus.pp_valid && (state_q == ACC);
        if (clear) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == ACC) begin
            if (xfer) begin
                acc_d = acc_q + (pp_ext << {cnt_q, 1'b0});
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_K) begin
                    state_d = HOLD;
                end
            end
        end else if (bus.prod_ready) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    assign bus.pp_ready   = (state_q == ACC);
    assign bus.prod_valid = (state_q == HOLD);
    assign bus.prod       = acc_q;
    assign bus.pp_cnt     = cnt_q;
endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 Parameter: n, default 8, multiplicand/multiplier width; must be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous abort; discards any partial or held result.
REQ-005 pp_valid  input  1  upstream Booth stage presents a partial product.
REQ-006 pp_ready  output  1  block can accept a partial product this cycle.
REQ-007 pp_in  input  n+2  signed two's-complement Booth partial product (-2..+2 times md), unshifted.
REQ-008 prod_valid  output  1  completed product available.
REQ-009 prod_ready  input  1  downstream consumer accepts the product.
REQ-010 prod  output  2n  signed product, two's complement.
REQ-011 pp_cnt  output  log2(n/2)+1  number of partial products accepted for the current product.

Function
REQ-012 The block SHALL implement a two-state FSM: ACC (collecting) and HOLD (result presented).
REQ-013 A PP transfer SHALL occur exactly when pp_valid && pp_ready at a rising edge.
REQ-014 In ACC, pp_ready SHALL be 1; in HOLD, pp_ready SHALL be 0 and pp_in/pp_valid SHALL be ignored.
REQ-015 The k-th accepted PP (k = 0..n/2-1) SHALL be sign-extended to 2n bits, shifted left by 2k, and added to the accumulator, modulo 2^(2n).
REQ-016 pp_cnt SHALL increment by 1 per transfer; there SHALL be no change on cycles without a transfer.
REQ-017 On the transfer with k = n/2-1, the FSM SHALL move to HOLD; prod_valid SHALL be 1 from the next cycle; prod SHALL equal the final sum (latency: 1 cycle after last PP).
REQ-018 Gaps (pp_valid = 0) between PPs SHALL NOT affect the result.
REQ-019 In HOLD, prod and prod_valid SHALL remain stable until prod_valid && prod_ready.
REQ-020 On handoff, the next cycle SHALL have state ACC, accumulator 0, pp_cnt 0, prod_valid 0; the first new PP is accepted no earlier than that cycle.
REQ-021 prod SHALL be driven from the accumulator register; in ACC its value is don't-care for consumers but SHALL equal the running sum.
REQ-022 If clear is 1 at an edge, the block SHALL enter ACC with accumulator 0 and pp_cnt 0, and prod_valid 0; a PP presented in the same cycle SHALL be dropped.
REQ-023 clear SHALL take priority over transfer and handoff; reset SHALL take priority over clear.
REQ-024 If prod_ready is 1 while prod_valid is 0, it SHALL have no effect.
REQ-025 Minimum throughput: one product per n/2+1 cycles.

Reset
REQ-026 At a rising edge with reset = 1: state ACC, accumulator 0, prod = 0, pp_cnt = 0, prod_valid = 0, pp_ready = 1 from the following cycle.
REQ-027 Reset asserted mid-accumulation or in HOLD SHALL discard all data; there SHALL be no partial output.

Verification
REQ-028 n=8, md=7, mr=3: pp_in = 10'h3F9, 10'h007, 10'h000, 10'h000 on 4 consecutive cycles -> prod_valid next cycle, prod = 16'h0015.
REQ-029 md=-128, mr=-128: pp_in = 0, 0, 0, 10'h100 -> prod = 16'h4000 (maximum-magnitude case, no overflow).
REQ-030 Same stimulus as REQ-028 with pp_valid low for 2 cycles between each PP -> prod = 16'h0015; pp_cnt steps 0,1,2,3,4 only on transfers.
REQ-031 prod_ready held 0 for 3 cycles in HOLD while pp_valid = 1 -> prod, prod_valid stable, pp_ready = 0, pp_cnt = 4; handoff on the 4th cycle, then pp_cnt = 0.
REQ-032 clear after 2 PPs, then the full REQ-029 sequence -> prod = 16'h4000 (no residue); clear in HOLD -> prod_valid 0 next cycle.
REQ-033 reset pulsed in HOLD with prod_ready = 0 -> next cycle prod_valid = 0, prod = 16'h0000, pp_ready = 1.
